mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory between two requesters: the multicycle CPU control path (port cpu) and a host loader/debug port (port host).
- Serialises accesses through a 3-state FSM with round-robin priority and a host lock.
- Returns read data in a per-port held register, so the CPU FSM can stall in any state until its access is acknowledged.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the shared memory and the arbiter.
// master = requester/memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU control-path port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  // Host loader / debug port
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_lock;

  // Unified memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_ack, host_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_ack, host_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified instruction/data memory.
// IDLE samples requests, ISSUE drives the memory for one cycle, RESP acks the
// winner and captures read data into that port's held rdata register.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstb,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {PORT_CPU = 1'b0, PORT_HOST = 1'b1} port_t;

  state_t            state_reg;
  port_t             last_gnt_reg;
  port_t             sel_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] cpu_rdata_reg;
  logic [DATA_W-1:0] host_rdata_reg;
  logic              cpu_ack_reg;
  logic              host_ack_reg;
  logic              busy_reg;

  logic cpu_elig;
  logic host_elig;
  logic pick_cpu;

  // The lock makes the CPU invisible to arbitration without touching its request.
  assign cpu_elig  = bus.cpu_req & ~bus.host_lock;
  assign host_elig = bus.host_req;
  // On a tie the port that did not win last time goes first.
  assign pick_cpu  = cpu_elig & (~host_elig | (last_gnt_reg == PORT_HOST));

  // Arbitration FSM with registered acks, busy and held read data.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_reg      <= IDLE;
      last_gnt_reg   <= PORT_HOST;
      sel_reg        <= PORT_CPU;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cpu_rdata_reg  <= '0;
      host_rdata_reg <= '0;
      cpu_ack_reg    <= 1'b0;
      host_ack_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (cpu_elig || host_elig) begin
            state_reg    <= ISSUE;
            busy_reg     <= 1'b1;
            sel_reg      <= pick_cpu ? PORT_CPU : PORT_HOST;
            last_gnt_reg <= pick_cpu ? PORT_CPU : PORT_HOST;
            we_reg       <= pick_cpu ? bus.cpu_we    : bus.host_we;
            addr_reg     <= pick_cpu ? bus.cpu_addr  : bus.host_addr;
            wdata_reg    <= pick_cpu ? bus.cpu_wdata : bus.host_wdata;
          end
        end
        ISSUE: begin
          state_reg    <= RESP;
          cpu_ack_reg  <= (sel_reg == PORT_CPU);
          host_ack_reg <= (sel_reg == PORT_HOST);
        end
        RESP: begin
          state_reg    <= IDLE;
          busy_reg     <= 1'b0;
          cpu_ack_reg  <= 1'b0;
          host_ack_reg <= 1'b0;
          // Memory read data arrives one cycle after ISSUE, i.e. now.
          if (!we_reg) begin
            if (sel_reg == PORT_CPU) cpu_rdata_reg  <= bus.mem_rdata;
            else                     host_rdata_reg <= bus.mem_rdata;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset forces every output low immediately, so a write caught mid-ISSUE never lands.
  assign bus.mem_we     = (state_reg == ISSUE) & we_reg & rstb;
  assign bus.mem_addr   = rstb ? addr_reg  : '0;
  assign bus.mem_wdata  = rstb ? wdata_reg : '0;
  assign bus.cpu_ack    = cpu_ack_reg & rstb;
  assign bus.host_ack   = host_ack_reg & rstb;
  assign bus.cpu_rdata  = rstb ? cpu_rdata_reg  : '0;
  assign bus.host_rdata = rstb ? host_rdata_reg : '0;
  assign bus.busy       = busy_reg & rstb;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks and
// writes, a monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read memory model with a few preloaded words.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h24] <= 32'hCAFEF00D;
      mem[8'h30] <= 32'h55555555;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  typedef struct {
    bit          port;   // 0 = cpu, 1 = host
    logic [31:0] rdata;  // rdata of that port after the ack
    int          cyc;    // cycle the ack must appear in
  } exp_ack_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_wr_t;

  exp_ack_t ack_q[$];
  exp_wr_t  wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ack(input bit port, input logic [31:0] rdata, input int at);
    exp_ack_t e;
    e.port = port; e.rdata = rdata; e.cyc = at;
    ack_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_wr_t w;
    w.addr = addr; w.data = data;
    wr_q.push_back(w);
  endtask

  task automatic drive_cpu(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic drive_host(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.host_req = req; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},       32'(bus.busy),     32'h0);
    chk({tag, "_cpu_ack"},    32'(bus.cpu_ack),  32'h0);
    chk({tag, "_host_ack"},   32'(bus.host_ack), 32'h0);
    chk({tag, "_mem_we"},     32'(bus.mem_we),   32'h0);
    chk({tag, "_mem_addr"},   bus.mem_addr,      32'h0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata,     32'h0);
    chk({tag, "_cpu_rdata"},  bus.cpu_rdata,     32'h0);
    chk({tag, "_host_rdata"}, bus.host_rdata,    32'h0);
  endtask

  // Lone transaction on one port: request at this negedge, ack 2 cycles later.
  task automatic single(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
    @(negedge clk);
    if (port) drive_host(1'b1, we, addr, wdata);
    else      drive_cpu(1'b1, we, addr, wdata);
    if (we) push_wr(addr, wdata);
    push_ack(port, exp_rdata, cyc + 2);
    repeat (3) @(negedge clk);
    if (port) drive_host(1'b0, 1'b0, 32'h0, 32'h0);
    else      drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: samples shortly before each rising edge.
  bit          rd_pend = 1'b0;
  bit          rd_port = 1'b0;
  logic [31:0] rd_exp = 32'h0;
  bit          we_pend = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rd_pend) begin
        rd_pend = 1'b0;
        if (rd_port) begin
          chk("host_ack_single_cycle", 32'(bus.host_ack), 32'h0);
          chk("host_rdata", bus.host_rdata, rd_exp);
        end else begin
          chk("cpu_ack_single_cycle", 32'(bus.cpu_ack), 32'h0);
          chk("cpu_rdata", bus.cpu_rdata, rd_exp);
        end
      end
      if (we_pend) begin
        we_pend = 1'b0;
        chk("mem_we_single_cycle", 32'(bus.mem_we), 32'h0);
      end
      if (bus.cpu_ack || bus.host_ack) begin
        chk("acks_exclusive", 32'(bus.cpu_ack & bus.host_ack), 32'h0);
        chk("busy_during_ack", 32'(bus.busy), 32'h1);
        if (ack_q.size() == 0) begin
          chk("unexpected_ack_host", 32'(bus.host_ack), 32'h0);
          chk("unexpected_ack_cpu", 32'(bus.cpu_ack), 32'h0);
        end else begin
          exp_ack_t e;
          e = ack_q.pop_front();
          chk("ack_port", 32'(bus.host_ack), 32'(e.port));
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          rd_pend = 1'b1;
          rd_port = e.port;
          rd_exp  = e.rdata;
        end
      end
      if (bus.mem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_mem_we", 32'(bus.mem_we), 32'h0);
        end else begin
          exp_wr_t w;
          w = wr_q.pop_front();
          chk("mem_addr", bus.mem_addr, w.addr);
          chk("mem_wdata", bus.mem_wdata, w.data);
          we_pend = 1'b1;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int c;
    int lows;
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_host(1'b0, 1'b0, 32'h0, 32'h0);
    bus.host_lock = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #4;
    check_all_zero("reset");
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    #4;
    check_all_zero("post_reset");

    // CPU read 0x10
    single(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    $display("txn cpu read 0x10 done, cpu_rdata=%h", bus.cpu_rdata);

    // Host write 0x20, then CPU read it back
    single(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0);
    $display("txn host write 0x20 done, host_rdata=%h", bus.host_rdata);
    single(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678);
    $display("txn cpu read 0x20 done, cpu_rdata=%h", bus.cpu_rdata);

    // Both ports from reset: cpu, host, cpu, host
    @(negedge clk);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    c = cyc;
    drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    drive_host(1'b1, 1'b0, 32'h20, 32'h0);
    push_ack(1'b0, 32'hDEADBEEF, c + 2);
    push_ack(1'b1, 32'h12345678, c + 5);
    push_ack(1'b0, 32'hDEADBEEF, c + 8);
    push_ack(1'b1, 32'h12345678, c + 11);
    lows = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      #4;
      if (!bus.busy) lows++;
    end
    chk("rr_busy_low_gaps", 32'(lows), 32'd3);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_host(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    $display("txn round-robin x4 done, busy gaps=%0d", lows);

    // host_lock: only host served, then CPU right after unlock
    @(negedge clk);
    c = cyc;
    bus.host_lock = 1'b1;
    drive_cpu(1'b1, 1'b0, 32'h24, 32'h0);
    drive_host(1'b1, 1'b0, 32'h20, 32'h0);
    push_ack(1'b1, 32'h12345678, c + 2);
    push_ack(1'b1, 32'h12345678, c + 5);
    push_ack(1'b1, 32'h12345678, c + 8);
    push_ack(1'b0, 32'hCAFEF00D, c + 11);
    push_ack(1'b1, 32'h12345678, c + 14);
    repeat (8) @(negedge clk);
    bus.host_lock = 1'b0;
    repeat (7) @(negedge clk);
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_host(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    $display("txn host_lock sequence done, cpu_rdata=%h", bus.cpu_rdata);

    // Reset during ISSUE of a host write to 0x30
    @(negedge clk);
    drive_host(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
    @(negedge clk);
    rstb = 1'b0;
    drive_cpu(1'b1, 1'b0, 32'h24, 32'h0);
    repeat (2) @(negedge clk);
    #4;
    check_all_zero("reset_in_issue");
    chk("mem30_untouched", mem[8'h30], 32'h55555555);
    @(negedge clk);
    rstb = 1'b1;
    c = cyc;
    push_ack(1'b0, 32'hCAFEF00D, c + 2);
    push_wr(32'h30, 32'hA5A5A5A5);
    push_ack(1'b1, 32'h0, c + 5);
    repeat (6) @(negedge clk);
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    drive_host(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("mem30_written_after_release", mem[8'h30], 32'hA5A5A5A5);
    $display("txn reset-abort then cpu-first done, mem[0x30]=%h", mem[8'h30]);

    // CPU request pulsed while host is busy is never seen
    @(negedge clk);
    c = cyc;
    drive_host(1'b1, 1'b0, 32'h20, 32'h0);
    push_ack(1'b1, 32'h12345678, c + 2);
    @(negedge clk);
    drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive_host(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    #4;
    chk("pulse_no_cpu_latch_mem_addr", bus.mem_addr, 32'h20);
    chk("pulse_idle_busy", 32'(bus.busy), 32'h0);
    $display("txn cpu pulse during host busy done, mem_addr=%h", bus.mem_addr);

    // Anything still queued never showed up
    repeat (2) @(negedge clk);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'h0);
    chk("write_queue_drained", 32'(wr_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
